fetch_unit: RTL

//  IF stage. Owns the PC register, drives the instruction SRAM request and

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_redirect_buf.sv | 40 ++++
 rtl/fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, bus layouts and FSM state codes for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned STALL_W     = 6;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned BR_WD       = 33;
    localparam int unsigned IF_TO_ID_WD = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        FETCH_ST_BOOT = 2'd0,
        FETCH_ST_RUN  = 2'd1,
        FETCH_ST_HOLD = 2'd2
    } fetch_st_e;

    typedef struct packed {
        logic              br_e;
        logic [ADDR_W-1:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic              ce;
        logic [ADDR_W-1:0] pc;
    } if_to_id_t;

endpackage

// File: rtl/fetch_redirect_buf.sv
// Holds a redirect taken while fetch is stalled and selects the next PC.
module fetch_redirect_buf
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_capture,
    input  logic              i_clear,
    input  logic              i_br_e,
    input  logic [ADDR_W-1:0] i_br_addr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_next_pc_c
);

    logic              r_pend_v;
    logic [ADDR_W-1:0] r_pend_addr;

    // Newest redirect during a stall wins; cleared when the stall releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
        end else if (i_capture && i_br_e) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= i_br_addr;
        end else if (i_clear) begin
            r_pend_v    <= 1'b0;
        end
    end

    always_comb begin
        o_next_pc_c = i_pc + ADDR_W'(4);
        if (i_br_e) begin
            o_next_pc_c = i_br_addr;
        end else if (r_pend_v) begin
            o_next_pc_c = r_pend_addr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register and boot/run/hold FSM, instruction SRAM request, IF->ID bus.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   if_adel,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_we,
    output logic [ADDR_W-1:0]      inst_sram_addr,
    output logic [ADDR_W-1:0]      inst_sram_wdata
);

    fetch_st_e         r_state;
    fetch_st_e         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_ce;
    logic              w_ce_nxt;
    logic              r_adel;
    logic              w_capture;
    logic              w_release;
    logic [ADDR_W-1:0] w_next_pc;
    br_bus_t           w_br;
    if_to_id_t         w_if_to_id;
    logic              w_unused_stall;

    assign w_br           = br_bus_t'(br_bus);
    assign w_unused_stall = ^stall[STALL_W-1:1];

    fetch_redirect_buf u_redirect (
        .clk         (clk),
        .rst_n       (rst),
        .i_capture   (w_capture),
        .i_clear     (w_release),
        .i_br_e      (w_br.br_e),
        .i_br_addr   (w_br.br_addr),
        .i_pc        (r_pc),
        .o_next_pc_c (w_next_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH_ST_BOOT;
            r_pc    <= RESET_VECTOR - ADDR_W'(4);
            r_ce    <= 1'b0;
            r_adel  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ce    <= w_ce_nxt;
            r_adel  <= |w_pc_nxt[1:0];
        end
    end

    // Boot ignores stall and redirect; stalls park in HOLD so redirects are buffered.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ce_nxt    = r_ce;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            FETCH_ST_BOOT: begin
                w_state_nxt = FETCH_ST_RUN;
                w_pc_nxt    = RESET_VECTOR;
                w_ce_nxt    = 1'b1;
            end
            FETCH_ST_RUN: begin
                if (stall[0] == STOP) begin
                    w_state_nxt = FETCH_ST_HOLD;
                    w_capture   = 1'b1;
                end else begin
                    w_pc_nxt = w_next_pc;
                    w_ce_nxt = 1'b1;
                end
            end
            FETCH_ST_HOLD: begin
                if (stall[0] == STOP) begin
                    w_capture = 1'b1;
                end else begin
                    w_state_nxt = FETCH_ST_RUN;
                    w_pc_nxt    = w_next_pc;
                    w_ce_nxt    = 1'b1;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FETCH_ST_BOOT;
            end
        endcase
    end

    assign w_if_to_id.ce = r_ce;
    assign w_if_to_id.pc = r_pc;

    assign if_to_id_bus    = IF_TO_ID_WD'(w_if_to_id);
    assign if_adel         = r_adel;
    assign inst_sram_en    = r_ce;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wdata = '0;

endmodule
